// File: rtl/stage_if_fetch_pkg.sv
// stage_if_fetch_pkg: shared opcodes, fetch state encoding and immediate decoders
package stage_if_fetch_pkg;

   localparam int ADDR_WIDTH_DEF = 32;

   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_DROP = 2'd3
   } fetch_state_e;

   // Sign-extended J-type immediate (JAL target offset)
   function automatic logic [31:0] imm_j(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

   // Sign-extended B-type immediate (conditional branch offset)
   function automatic logic [31:0] imm_b(input logic [31:0] inst);
      return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
   endfunction

endpackage

// File: rtl/stage_if_fetch_predictor.sv
// if_static_predictor: static prediction, JAL and backward branches taken
module if_static_predictor
   import stage_if_fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic [ADDR_WIDTH-1:0] pc_i,
   input  logic [31:0]           inst_i,
   output logic [ADDR_WIDTH-1:0] next_pc_o,
   output logic                  pred_o
);

   logic        is_jal;
   logic        is_bwd;
   logic [31:0] imm;

   // Pick the offset of the predicted-taken form; fall through to pc+4 otherwise
   always_comb begin
      is_jal    = inst_i[6:0] == OP_JAL;
      is_bwd    = inst_i[6:0] == OP_BRANCH && inst_i[31];
      imm       = is_jal ? imm_j(inst_i) : imm_b(inst_i);
      pred_o    = is_jal || is_bwd;
      next_pc_o = pc_i + (pred_o ? ADDR_WIDTH'($signed(imm)) : ADDR_WIDTH'(4));
   end

endmodule

// File: rtl/stage_if_fetch.sv
// stage_if_fetch: PC holder and single-outstanding fetch engine feeding IF/ID
module stage_if_fetch
   import stage_if_fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  stall_i,
   input  logic                  redirect_i,
   input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
   output logic                  mem_req_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   input  logic                  mem_ready_i,
   input  logic                  mem_done_i,
   input  logic [31:0]           mem_data_i,
   output logic [ADDR_WIDTH-1:0] pc_o,
   output logic [31:0]           inst_o,
   output logic                  prediction_o,
   output logic                  stall_req_o
);

   fetch_state_e          state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [ADDR_WIDTH-1:0] next_pc_q, next_pc_d;
   logic [31:0]           inst_q, inst_d;
   logic                  pred_q, pred_d;
   logic [ADDR_WIDTH-1:0] pred_next_pc;
   logic                  pred_taken;
   logic                  valid;

   if_static_predictor #(.ADDR_WIDTH(ADDR_WIDTH)) u_pred (
      .pc_i      (pc_q),
      .inst_i    (mem_data_i),
      .next_pc_o (pred_next_pc),
      .pred_o    (pred_taken)
   );

   // State and fetch-buffer registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         next_pc_q <= '0;
         inst_q    <= '0;
         pred_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         next_pc_q <= next_pc_d;
         inst_q    <= inst_d;
         pred_q    <= pred_d;
      end
   end

   // Next state; a redirect overrides the normal flow and keeps a granted request tracked in DROP
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      next_pc_d = next_pc_q;
      inst_d    = inst_q;
      pred_d    = pred_q;
      case (state_q)
         S_REQ:   state_d = mem_ready_i ? S_WAIT : S_REQ;
         S_WAIT: begin
            if (mem_done_i) begin
               state_d   = S_HOLD;
               inst_d    = mem_data_i;
               next_pc_d = pred_next_pc;
               pred_d    = pred_taken;
            end
         end
         S_HOLD: begin
            if (!stall_i) begin
               state_d = S_REQ;
               pc_d    = next_pc_q;
            end
         end
         default: state_d = mem_done_i ? S_REQ : S_DROP;
      endcase
      if (redirect_i) begin
         pc_d    = {redirect_pc_i[ADDR_WIDTH-1:2], 2'b00};
         state_d = ((state_q == S_REQ && mem_ready_i) ||
                    (state_q == S_WAIT && !mem_done_i) ||
                    (state_q == S_DROP && !mem_done_i)) ? S_DROP : S_REQ;
      end
   end

   assign valid        = state_q == S_HOLD && !redirect_i;
   assign mem_req_o    = reset_n && state_q == S_REQ;
   assign mem_addr_o   = {pc_q[ADDR_WIDTH-1:2], 2'b00};
   assign pc_o         = valid ? pc_q : '0;
   assign inst_o       = valid ? inst_q : '0;
   assign prediction_o = valid && pred_q;
   assign stall_req_o  = !valid;

endmodule

// File: tb/tb_stage_if_fetch.sv
// tb_stage_if_fetch: randomized scoreboard bench against a program-flow reference model
module tb_stage_if_fetch;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        stall_i = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = '0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i = 1'b0;
   logic        mem_done_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   logic [31:0] pc_o;
   logic [31:0] inst_o;
   logic        prediction_o;
   logic        stall_req_o;

   int vectors = 0;
   int errs = 0;
   bit sim_done = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred;
      logic [31:0] nxt;
   } item_t;

   item_t       exp_q[$];
   logic [31:0] model_pc;

   stage_if_fetch #(.ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .mem_req_o     (mem_req_o),
      .mem_addr_o    (mem_addr_o),
      .mem_ready_i   (mem_ready_i),
      .mem_done_i    (mem_done_i),
      .mem_data_i    (mem_data_i),
      .pc_o          (pc_o),
      .inst_o        (inst_o),
      .prediction_o  (prediction_o),
      .stall_req_o   (stall_req_o)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc_j(input int off, input logic [4:0] rd);
      logic [31:0] o;
      o = off;
      return {o[20], o[10:1], o[11], o[19:12], rd, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_b(input int off, input logic [31:0] h);
      logic [31:0] o;
      o = off;
      return {o[12], o[10:5], h[24:20], h[19:15], h[14:12], o[4:1], o[11], 7'b1100011};
   endfunction

   // Program image: each word carries its own intended prediction and successor PC
   function automatic item_t mem_item(input logic [31:0] a);
      item_t       it;
      logic [31:0] h;
      int          off;
      it.pc = a;
      case (a)
         32'h000: begin it.inst = 32'h00000013; it.pred = 0; it.nxt = 32'h004; end
         32'h008: begin it.inst = 32'h00100093; it.pred = 0; it.nxt = 32'h00C; end
         32'h100: begin it.inst = 32'h0100006F; it.pred = 1; it.nxt = 32'h110; end
         32'h200: begin it.inst = 32'hFE000EE3; it.pred = 1; it.nxt = 32'h1FC; end
         32'h1FC: begin it.inst = 32'h00000463; it.pred = 0; it.nxt = 32'h200; end
         default: begin
            h = a * 32'h9E3779B1;
            h = h ^ (h >> 15);
            case (h[2:0])
               3'd0, 3'd1: begin
                  off = (int'(h[11:4]) - 128) * 4;
                  it.inst = enc_j(off, h[16:12]); it.pred = 1; it.nxt = a + 32'(off);
               end
               3'd2: begin
                  off = -((int'(h[10:4]) + 1) * 4);
                  it.inst = enc_b(off, h); it.pred = 1; it.nxt = a + 32'(off);
               end
               3'd3: begin
                  off = (int'(h[10:4]) + 1) * 4;
                  it.inst = enc_b(off, h); it.pred = 0; it.nxt = a + 32'd4;
               end
               default: begin
                  it.inst = {h[31:12], h[11:7], 7'b0010011}; it.pred = 0; it.nxt = a + 32'd4;
               end
            endcase
         end
      endcase
      return it;
   endfunction

   task automatic refill();
      item_t it;
      while (exp_q.size() < 4) begin
         it = mem_item(model_pc);
         exp_q.push_back(it);
         model_pc = it.nxt;
      end
   endtask

   task automatic restart(input logic [31:0] a);
      exp_q.delete();
      model_pc = {a[31:2], 2'b00};
      refill();
   endtask

   task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
      vectors++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus: memory controller, stalls, redirects and occasional mid-run reset
   initial begin
      bit          pending = 0;
      int          cnt = 0;
      logic [31:0] paddr = '0;
      logic [31:0] tgt;
      item_t       it;
      restart(32'h0);
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(posedge clock);
         #1;
         if (!reset_n) reset_n = 1'b1;
         mem_ready_i = 1'b0;
         mem_done_i  = 1'b0;
         mem_data_i  = $urandom;
         if (pending) begin
            if (cnt == 0) begin
               it = mem_item(paddr);
               mem_done_i = 1'b1;
               mem_data_i = it.inst;
               pending = 0;
            end else cnt--;
         end else if (mem_req_o && $urandom_range(0, 2) != 0) begin
            mem_ready_i = 1'b1;
            pending = 1;
            paddr = mem_addr_o;
            cnt = $urandom_range(0, 3);
         end
         stall_i = $urandom_range(0, 9) < 3;
         redirect_i = $urandom_range(0, 99) < 4;
         redirect_pc_i = $urandom;
         if (redirect_i) begin
            case ($urandom_range(0, 4))
               0: tgt = 32'h100;
               1: tgt = 32'h200;
               2: tgt = 32'h008;
               3: tgt = 32'h000;
               default: tgt = $urandom_range(0, 4095);
            endcase
            redirect_pc_i = tgt;
            restart(tgt);
         end
         if (cyc > 100 && $urandom_range(0, 249) == 0) begin
            redirect_i = 1'b0;
            reset_n = 1'b0;
            restart(32'h0);
         end
      end
      sim_done = 1;
      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

   // Monitor: pops expected instructions as IF/ID consumes them
   initial begin
      bit          prev_valid = 0;
      bit          prev_stall = 0;
      logic [64:0] prev_out = '0;
      int          idle = 0;
      item_t       e;
      forever begin
         @(negedge clock);
         if (sim_done) break;
         idle++;
         if (!reset_n) begin
            check("reset", {mem_req_o, stall_req_o, pc_o, inst_o, 1'b0, prediction_o},
                  {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0});
            prev_valid = 0;
            idle = 0;
            continue;
         end
         if (redirect_i) begin
            check("redirect", {1'b0, stall_req_o, pc_o, inst_o, 1'b0, prediction_o},
                  {1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0});
            prev_valid = 0;
            idle = 0;
            continue;
         end
         if (mem_req_o && mem_ready_i)
            check("req_addr", {36'h0, mem_addr_o}, {36'h0, exp_q[0].pc});
         if (prev_valid && prev_stall)
            check("hold", {2'b0, mem_req_o, stall_req_o, pc_o, inst_o, prediction_o},
                  {2'b0, 1'b0, 1'b0, prev_out});
         if (!stall_req_o) begin
            if (!stall_i) begin
               if (exp_q.size() == 0) begin
                  check("consume_empty", 68'h1, 68'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("consume", {3'b0, pc_o, inst_o, prediction_o}, {3'b0, e.pc, e.inst, e.pred});
                  refill();
               end
               idle = 0;
            end
         end else begin
            check("idle_zero", {3'b0, pc_o, inst_o, prediction_o}, 68'h0);
         end
         prev_valid = !stall_req_o;
         prev_stall = stall_i;
         prev_out = {pc_o, inst_o, prediction_o};
         if (idle > 300) begin
            check("watchdog", 68'h1, 68'h0);
            idle = 0;
         end
      end
   end

endmodule

// File: doc/stage_if_fetch.md
Name: stage_if_fetch

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Holds the PC and issues 32-bit fetch requests to the memory controller over a req/grant/done handshake.
- Applies static branch prediction and presents pc/inst/prediction to IF/ID.
- Raises a stall request while no instruction is ready, and restarts fetch on redirects from EX.

Parameters:
- ADDR_WIDTH, 32, width of PC and memory address.
- RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clock  in  1  single clock; all state on posedge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  downstream stall (stall[2]); hold the current instruction.
- redirect_i  in  1  EX mispredict/jump; also drives IF/ID discard.
- redirect_pc_i  in  ADDR_WIDTH  corrected PC.
- mem_req_o  out  1  fetch request.
- mem_addr_o  out  ADDR_WIDTH  fetch address, word-aligned.
- mem_ready_i  in  1  controller grant; request accepted this cycle.
- mem_done_i  in  1  one-cycle pulse; mem_data_i is valid.
- mem_data_i  in  32  fetched instruction.
- pc_o  out  ADDR_WIDTH  instruction PC to IF/ID; 0 when not valid.
- inst_o  out  32  instruction to IF/ID; 0 when not valid.
- prediction_o  out  1  1 = predicted taken.
- stall_req_o  out  1  stall[1] source; 1 when no valid instruction is offered.

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC, state=REQ, inst buffer=0, next_pc=0, pred=0.
- Reset outputs: mem_req_o=0 while reset_n=0; pc_o=0, inst_o=0, prediction_o=0, stall_req_o=1.
- Reset mid-request: any outstanding done after reset release is ignored.
  - Rule: a mem_done_i arriving in state REQ is ignored.
  - The controller is reset by the same reset_n.
- State REQ:
  - mem_req_o=1, mem_addr_o=pc.
  - mem_ready_i=1 -> WAIT.
- State WAIT:
  - mem_req_o=0.
  - mem_done_i=1 -> latch inst=mem_data_i and next_pc/pred from the predictor -> HOLD.
- Predictor (combinational on mem_data_i and pc, 32-bit wrap-around add):
  - opcode 1101111 (JAL): next_pc=pc+J-imm, pred=1.
  - opcode 1100011 with imm[12]=1 (backward branch): next_pc=pc+B-imm, pred=1.
  - Otherwise: next_pc=pc+4, pred=0.
- State HOLD:
  - Outputs valid: pc_o=pc, inst_o=inst, prediction_o=pred, stall_req_o=0.
  - stall_i=0: consumed this cycle; pc<=next_pc -> REQ.
  - stall_i=1: stay; all outputs stable.
- State DROP: wrong-path request in flight.
  - mem_req_o=0.
  - mem_done_i=1 -> discard data -> REQ.
- Redirect (redirect_i=1, priority over everything except reset): pc<=redirect_pc_i; stall_req_o=1 that cycle; outputs zero. Transition by state:
  - REQ & mem_ready_i=1 -> DROP.
  - REQ & mem_ready_i=0 -> REQ.
  - WAIT & mem_done_i=0 -> DROP.
  - WAIT & mem_done_i=1 -> REQ (data discarded).
  - HOLD -> REQ.
  - DROP & mem_done_i=0 -> DROP.
  - DROP & mem_done_i=1 -> REQ.
- Latency: at most one outstanding request. With 0-cycle grant and done D cycles after grant, an instruction is valid in HOLD D+1 cycles after entering REQ.
- stall_req_o = (state!=HOLD) | redirect_i.
- mem_addr_o[1:0] always 00. redirect_pc_i is assumed aligned by EX; bits [1:0] are forced to 0.

Decomposition:
- Shared package/define file:
  - opcode constants OP_JAL=7'b1101111, OP_BRANCH=7'b1100011.
  - fetch state encoding (REQ, WAIT, HOLD, DROP; 2 bits).
  - ADDR_WIDTH default.
- One sub-module: if_static_predictor.
  - Combinational; inputs pc, inst; outputs next_pc, pred.
  - Decodes J/B immediates; reusable by a later BTB stage.

Test Plan:
- Reset release, RESET_PC=0, grant immediate, done 3 cycles later with 32'h00000013 -> mem_addr_o=0; then pc_o=0, inst_o=13, prediction_o=0, stall_req_o=0; next request address 4.
- JAL at pc=0x100, inst 32'h0100006F (imm +16) -> prediction_o=1; next mem_addr_o=0x110.
- Backward BEQ at pc=0x200, inst 32'hFE000EE3 (imm -4) -> prediction_o=1; next fetch 0x1FC. Forward BEQ 32'h00000463 -> prediction_o=0; next fetch 0x204.
- stall_i=1 for 5 cycles in HOLD with inst 0x00100093 at pc 0x8 -> outputs held for all 5 cycles, mem_req_o=0; release -> fetch 0xC.
- redirect_i to 0x400 while in WAIT -> DROP; the following done (data 0xDEADBEEF) never appears on inst_o; next mem_addr_o=0x400.
- redirect_i coincident with mem_done_i in WAIT -> data discarded, direct REQ at redirect PC. reset_n low mid-WAIT -> outputs 0 immediately, restart at RESET_PC.
